// File: rtl/row_assembler_if.sv
// rtl/row_assembler_if.sv - element input and row output handshake bundle for row_assembler
interface row_assembler_if #(
   parameter int SIZE = 4
);
   logic                           enable;
   logic                           flush;
   logic                           in_valid;
   logic [7:0]                     in_data;
   logic                           in_ready;
   logic                           out_valid;
   logic                           out_ready;
   logic [SIZE-1:0][7:0]           out_data;
   logic [$clog2(SIZE+1)-1:0]      count;

   modport master (
      output enable, flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  enable, flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/row_assembler.sv
// rtl/row_assembler.sv - packs a byte stream into SIZE-byte rows presented with valid/ready
module row_assembler #(
   parameter int SIZE = 4
) (
   input  logic            clk,
   input  logic            reset,
   row_assembler_if.slave  bus
);
   localparam int IDX_W = $clog2(SIZE);
   localparam int CNT_W = $clog2(SIZE+1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [CNT_W-1:0]     count_q;
   logic                 out_valid_q;
   logic [SIZE-1:0][7:0] data_q;

   // in_ready must not depend on in_valid/out_ready, only on state and enable
   assign bus.in_ready  = (state == FILL) && bus.enable;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = data_q;
   assign bus.count     = count_q;

   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         state       <= FILL;
         idx         <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         data_q      <= '0;
      end else begin
         case (state)
            FILL: begin
               if (bus.in_valid && bus.enable) begin
                  data_q[idx] <= bus.in_data;
                  if (idx == IDX_W'(SIZE-1)) begin
                     idx         <= '0;
                     count_q     <= CNT_W'(SIZE);
                     out_valid_q <= 1'b1;
                     state       <= HOLD;
                  end else begin
                     idx     <= idx + 1'b1;
                     count_q <= count_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               // a taken row leaves zeroed slots so the next partial row reads 0 beyond its fill
               if (bus.out_ready) begin
                  state       <= FILL;
                  count_q     <= '0;
                  out_valid_q <= 1'b0;
                  data_q      <= '0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_row_assembler.sv
// tb/tb_row_assembler.sv - directed SIZE=4 vectors and randomized SIZE=8 scoreboard run
module tb_row_assembler;
   logic clk = 1'b0;
   logic r4  = 1'b1;
   logic r8  = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   row_assembler_if #(.SIZE(4)) b4 ();
   row_assembler_if #(.SIZE(8)) b8 ();

   row_assembler #(.SIZE(4)) dut4 (.clk(clk), .reset(r4), .bus(b4.slave));
   row_assembler #(.SIZE(8)) dut8 (.clk(clk), .reset(r8), .bus(b8.slave));

   typedef struct {
      bit          en, fl, iv;
      logic [7:0]  d;
      bit          ordy;
      bit          ir, ov;
      int          cnt;
      logic [31:0] dat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", name, act, exp);
      end
   endtask

   // drive one cycle on the SIZE=4 instance, check pre-edge outputs at negedge, then advance
   task automatic st4(input bit en, input bit fl, input bit iv, input logic [7:0] d, input bit ordy,
                      input string tag, input bit ir, input bit ov, input int cnt, input logic [31:0] dat);
      b4.enable = en; b4.flush = fl; b4.in_valid = iv; b4.in_data = d; b4.out_ready = ordy;
      @(negedge clk);
      chk({tag, ".in_ready"},  64'(b4.in_ready),  64'(ir));
      chk({tag, ".out_valid"}, 64'(b4.out_valid), 64'(ov));
      chk({tag, ".count"},     64'(b4.count),     64'(cnt));
      chk({tag, ".out_data"},  64'(b4.out_data),  64'(dat));
      @(posedge clk); #1;
   endtask

   vec_t        tbl[$];
   logic [7:0]  stream[64];
   logic [7:0]  cur[$];
   logic [63:0] mrow;
   int          ptr, rows, cyc;
   bit          en, iv, ordy, held;
   logic [7:0]  d;

   initial begin
      b4.enable = 1'b1; b4.flush = 1'b0; b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;
      b8.enable = 1'b1; b8.flush = 1'b0; b8.in_valid = 1'b0; b8.in_data = '0; b8.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1; r4 = 1'b0; r8 = 1'b0;

      // basic fill, hold with retries, release, enable gate, flush
      tbl.push_back('{1,0,1,8'h11,0, 1,0,0,32'h0});
      tbl.push_back('{1,0,1,8'h22,0, 1,0,1,32'h00000011});
      tbl.push_back('{1,0,1,8'h33,0, 1,0,2,32'h00002211});
      tbl.push_back('{1,0,1,8'h44,0, 1,0,3,32'h00332211});
      for (int i = 0; i < 5; i++) tbl.push_back('{1,0,1,8'h55,0, 0,1,4,32'h44332211});
      tbl.push_back('{1,0,1,8'h55,1, 0,1,4,32'h44332211});
      tbl.push_back('{1,0,1,8'h55,0, 1,0,0,32'h0});
      tbl.push_back('{0,0,1,8'h66,0, 0,0,1,32'h00000055});
      tbl.push_back('{1,1,1,8'hFF,0, 1,0,1,32'h00000055});
      tbl.push_back('{1,0,0,8'h00,0, 1,0,0,32'h0});
      foreach (tbl[i])
         st4(tbl[i].en, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy, $sformatf("vec%0d", i),
             tbl[i].ir, tbl[i].ov, tbl[i].cnt, tbl[i].dat);

      // stall mid-fill
      st4(1,0,1,8'hA0,0, "stall0", 1,0,0,32'h0);
      st4(1,0,1,8'hA1,0, "stall1", 1,0,1,32'h000000A0);
      for (int i = 0; i < 3; i++) st4(0,0,1,8'hA2,0, "stalled", 0,0,2,32'h0000A1A0);
      st4(1,0,1,8'hA2,0, "stall2", 1,0,2,32'h0000A1A0);
      st4(1,0,1,8'hA3,0, "stall3", 1,0,3,32'h00A2A1A0);
      st4(1,0,0,8'h00,1, "stallrow", 0,1,4,32'hA3A2A1A0);
      st4(1,0,0,8'h00,0, "stallrel", 1,0,0,32'h0);

      // flush mid-fill, refill, flush in HOLD
      st4(1,0,1,8'h01,0, "fl0", 1,0,0,32'h0);
      st4(1,0,1,8'h02,0, "fl1", 1,0,1,32'h00000001);
      st4(1,1,1,8'hFF,0, "flpart", 1,0,2,32'h00000201);
      st4(1,0,1,8'h01,0, "flrf0", 1,0,0,32'h0);
      st4(1,0,1,8'h02,0, "flrf1", 1,0,1,32'h00000001);
      st4(1,0,1,8'h03,0, "flrf2", 1,0,2,32'h00000201);
      st4(1,0,1,8'h04,0, "flrf3", 1,0,3,32'h00030201);
      st4(1,1,0,8'h00,0, "flhold", 0,1,4,32'h04030201);
      st4(1,0,0,8'h00,0, "flpost", 1,0,0,32'h0);

      // reset in HOLD and mid-fill
      st4(1,0,1,8'h09,0, "rs0", 1,0,0,32'h0);
      st4(1,0,1,8'h08,0, "rs1", 1,0,1,32'h00000009);
      st4(1,0,1,8'h07,0, "rs2", 1,0,2,32'h00000809);
      st4(1,0,1,8'h06,0, "rs3", 1,0,3,32'h00070809);
      r4 = 1'b1;
      st4(1,0,0,8'h00,0, "rshold", 0,1,4,32'h06070809);
      r4 = 1'b0;
      st4(1,0,1,8'h31,0, "rsclr", 1,0,0,32'h0);
      st4(1,0,1,8'h32,0, "rsf1", 1,0,1,32'h00000031);
      st4(1,0,1,8'h33,0, "rsf2", 1,0,2,32'h00003231);
      r4 = 1'b1;
      st4(1,0,0,8'h00,0, "rsmid", 1,0,3,32'h00333231);
      r4 = 1'b0;
      st4(1,0,1,8'h77,0, "rsclr2", 1,0,0,32'h0);
      st4(1,0,0,8'h00,0, "rsslot0", 1,0,1,32'h00000077);

      // SIZE=8 randomized round trip against a queue model
      foreach (stream[i]) stream[i] = 8'($urandom);
      ptr = 0; rows = 0; cyc = 0;
      while (rows < 8 && cyc < 3000) begin
         en   = ($urandom_range(0, 3) != 0);
         iv   = ($urandom_range(0, 2) != 0) && (ptr < 64);
         d    = iv ? stream[ptr] : 8'($urandom);
         ordy = ($urandom_range(0, 2) == 0);
         b8.enable = en; b8.in_valid = iv; b8.in_data = d; b8.out_ready = ordy;
         @(negedge clk);
         held = (cur.size() == 8);
         mrow = '0;
         foreach (cur[k]) mrow[k*8 +: 8] = cur[k];
         chk("rnd.in_ready",  64'(b8.in_ready),  64'(en && !held));
         chk("rnd.out_valid", 64'(b8.out_valid), 64'(held));
         chk("rnd.count",     64'(b8.count),     64'(cur.size()));
         chk("rnd.out_data",  64'(b8.out_data),  mrow);
         if (held && ordy) begin
            for (int k = 0; k < 8; k++)
               chk($sformatf("row%0d.byte%0d", rows, k), 64'(b8.out_data[k]), 64'(stream[rows*8 + k]));
            rows++;
            cur.delete();
         end else if (!held && en && iv) begin
            cur.push_back(d);
            ptr++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("rnd.rows_delivered", 64'(rows), 64'd8);
      chk("rnd.bytes_consumed", 64'(ptr), 64'd64);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/row_assembler.md
# row_assembler

Byte-to-row deserializer for the matrix processor datapath. Accepts a stream of 8-bit elements one per handshake and packs them, in arrival order, into a SIZE-byte row vector. It then presents the completed row with a valid/ready handshake. It is the inverse of the row serializer: element k of the stream lands in `out_data[k]`, so a serialized row reassembles unchanged.

## Interface
- `SIZE`, default 4: elements per row; legal range 2..16.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `enable`  in  1  input gate; low stalls element acceptance, no state change.
- `flush`  in  1  synchronous discard of the partial or held row.
- `in_valid`  in  1  `in_data` carries an element this cycle.
- `in_data`  in  8  element byte.
- `in_ready`  out  1  block accepts an element this cycle; combinational from state and `enable` only.
- `out_valid`  out  1  registered; a complete row is held on `out_data`.
- `out_ready`  in  1  consumer takes the row this cycle.
- `out_data`  out  SIZE×8, packed `[SIZE-1:0][7:0]`  assembled row, registered.
- `count`  out  $clog2(SIZE+1)  number of elements currently held (0..SIZE), registered.

## Operation
- Two states: FILL and HOLD. Reset state is FILL.
- Internal write index `idx`, width $clog2(SIZE), resets to 0.
- FILL:
  - `in_ready = enable`.
  - Accept when `in_valid & in_ready`: `out_data[idx] <= in_data`, `idx <= idx+1`, `count <= count+1`.
  - Accepting the element with `idx == SIZE-1` sets `idx <= 0`, `count <= SIZE`, `out_valid <= 1`, and moves to HOLD. There is no wrap inside FILL.
  - `out_valid` is 0 throughout FILL.
- HOLD:
  - `in_ready = 0` regardless of `enable`.
  - `out_data`, `out_valid = 1` and `count = SIZE` remain stable until taken.
  - `out_ready = 1` completes the transfer. Next cycle: state FILL, `out_valid = 0`, `count = 0`, all `out_data` slots cleared to 0.
  - `enable` does not affect the output handshake.
- `flush` (either state): next cycle is FILL with `idx = 0`, `count = 0`, `out_valid = 0` and `out_data` all zero. Any element presented in the flush cycle is dropped, even if `in_ready` was high.
- Priority: `reset` > `flush` > output handshake > input acceptance.
- Untouched slots of a partial row read 0.
- Slot order is strictly arrival order; there is no reordering.

## Timing
- Reset values: `out_valid = 0`, `count = 0`, `out_data = 0`, state FILL, `idx = 0`. `in_ready` follows `enable` in the first post-reset cycle.
- Latency: the SIZE-th element is accepted at edge N; `out_valid` is high from edge N and the row is valid in that cycle.
- An element accepted at edge N is visible on `out_data` and `count` after edge N.
- Throughput: at best, one row per SIZE+1 cycles (SIZE fill cycles plus one HOLD cycle with `out_ready` high).
- No combinational path from `in_valid`, `in_data` or `out_ready` to any output. `in_ready` depends only on `enable` and registered state.
- Simultaneous `out_ready` and `in_valid` in HOLD: the row is released and the element is not accepted. The producer retries in the next FILL cycle.
- `reset` or `flush` mid-fill or in HOLD: the row is lost; no partial `out_valid` pulse.
- `enable` low mid-fill: `idx` and `count` are frozen and `in_ready` is 0. Filling resumes at the same slot when `enable` returns high.

## Test plan
- Basic fill, SIZE=4, `out_ready = 0`: send 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> `count` reads 1, 2, 3, 4. After the 4th edge, `out_valid = 1`, `out_data[0..3] = 11, 22, 33, 44` and `in_ready = 0`.
- Hold and release: keep `out_ready = 0` for 5 cycles with `in_valid = 1` and data 0x55 -> row and `count = 4` are unchanged. Raise `out_ready` for one cycle -> next cycle `out_valid = 0`, `count = 0`, `out_data = 0`, `in_ready = 1`. 0x55 is then accepted into slot 0.
- Stall: send 0xA0 and 0xA1, drop `enable` for 3 cycles with `in_valid = 1`, then raise it and send 0xA2, 0xA3 -> `in_ready = 0` during the stall and `count` holds at 2. Final row is A0, A1, A2, A3.
- Flush: after 2 elements, assert `flush` while sending 0xFF -> next cycle `count = 0` and `out_data = 0`. Send 1, 2, 3, 4 -> row 1, 2, 3, 4. Repeat `flush` during HOLD -> `out_valid` drops with no transfer.
- Reset mid-operation: assert `reset` in HOLD and again after 3 elements -> all outputs return to reset values the next cycle and refill starts at slot 0.
- Round trip with SIZE=8: stream 64 random bytes with random `in_valid` and `out_ready` gaps -> 8 rows are delivered in order, each byte matches the scoreboard, and no row is lost or duplicated.
